ledr_pwm_driver: RTL and testbench
==================================

LEDR_PWM_DRIVER -- requirements
Module: ledr_pwm_driver

Interface
- REQ-001 SHALL have parameter NUM_LEDS, default 18: width of LED word in and LED pins out.
- REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter and brightness width.
- REQ-003 SHALL have parameter PRESCALE, default 50: clk cycles per PWM tick, legal range 1..65535.
- REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports are clk (input, 1, system clock) and reset_n (input, 1, async active-low reset).
- REQ-005 SHALL have led_word  input  NUM_LEDS: pattern from the upstream red-LED PIO out_port.
- REQ-006 SHALL have address  input  2: Avalon-MM config slave word address.
- REQ-007 SHALL have chipselect  input  1, write_n  input  1 (active-low), writedata  input  32.
- REQ-008 SHALL have readdata  output  32: combinational read mux, zero-extended.
- REQ-009 SHALL have ledr  output  NUM_LEDS: registered drive to physical LEDs.

Function
- REQ-010 SHALL decode a register write as chipselect=1, write_n=0. Writes take effect on the next clk edge. Reads have zero wait states.
- REQ-011 SHALL decode the register map as: 0 CTRL (bit0 enable, bit1 blink_en); 1 BRIGHT [PWM_BITS-1:0]; 2 BLINK_PERIOD [15:0], in PWM frames; 3 STATUS, read-only (bit0 blink_phase, bit1 frame_strobe_seen sticky, cleared by any write to 3).
- REQ-012 SHALL run a prescaler from 0 to PRESCALE-1, then wrap. Wrap cycle = tick.
- REQ-013 SHALL increment the PWM counter by 1 on each tick and wrap from 2^PWM_BITS-1 to 0. A tick that wraps the counter = frame strobe.
- REQ-014 SHALL latch led_word into a shadow register only on the frame strobe, so a mid-frame change does not appear until the next frame.
- REQ-015 SHALL compute duty: pwm_on = (pwm_cnt < duty), except duty = all-ones forces pwm_on=1 and duty=0 forces pwm_on=0.
- REQ-016 SHALL count frame strobes when blink_en=1. When the count equals BLINK_PERIOD-1, it SHALL toggle blink_phase and clear the count in the same cycle.
- REQ-017 SHALL hold blink_phase=1 and clear the count while BLINK_PERIOD=0 or blink_en=0.
- REQ-018 SHALL register ledr <= (enable & pwm_on & blink_phase) ? shadow : 0, giving one clk latency from counter state to pin.
- REQ-019 SHALL apply a BRIGHT or BLINK_PERIOD write immediately, with no restart of counters. A BLINK_PERIOD written below the current count SHALL make the count wrap through 65535 (no early toggle).
- REQ-020 SHALL give the register write priority for STATUS bit1 when a frame strobe and a write to address 3 occur in the same cycle (bit1 reads 0).

Reset
- REQ-021 SHALL, on reset_n=0 and asynchronously, clear ledr, CTRL, BRIGHT, BLINK_PERIOD, shadow, all counters and STATUS bit1, and set blink_phase=1.
- REQ-022 SHALL, on reset deassertion mid-frame, restart at prescaler=0, pwm_cnt=0, with no residual output.

Configuration
- REQ-023 SHALL, with LEDR_PWM_DRIVER_GAMMA_EN defined, use duty = (BRIGHT*BRIGHT) >> PWM_BITS. All-ones BRIGHT SHALL still force full on.
- REQ-024 SHALL, without LEDR_PWM_DRIVER_GAMMA_EN, use duty = BRIGHT (linear) and contain no multiplier.

Structure
- REQ-025 SHALL place register address constants, CTRL bit indices and the STATUS bit layout in package ledr_pwm_driver_pkg.
- REQ-026 SHALL implement the prescaler, PWM counter and frame strobe in sub-module ledr_pwm_timebase, which outputs tick, pwm_cnt and frame_strobe.

Verification (PRESCALE=2, PWM_BITS=8)
- REQ-027 SHALL check reset: reset_n low mid-run -> ledr=0, readdata at address 3 = 0x1.
- REQ-028 SHALL check duty: CTRL=1, BRIGHT=0x40, led_word=0x3FFFF -> ledr=0x3FFFF for exactly 128 clk of every 512-clk frame. BRIGHT=0xFF -> always on. BRIGHT=0 -> always 0.
- REQ-029 SHALL check the shadow: change led_word 0x00001->0x20000 mid-frame -> ledr keeps 0x00001 until the frame strobe, then 0x20000 one clk later.
- REQ-030 SHALL check blink: CTRL=3, BLINK_PERIOD=2, BRIGHT=0xFF -> ledr on 2 frames, off 2 frames, repeating. STATUS bit0 tracks the phase.
- REQ-031 SHALL check a simultaneous event: frame strobe coincident with a write to address 3 -> STATUS bit1 reads 0 afterwards.
- REQ-032 SHALL check the macro: with LEDR_PWM_DRIVER_GAMMA_EN defined, BRIGHT=0x80 -> 64 on-ticks per frame. Without it -> 128.

Source files
------------

// File: rtl/ledr_pwm_driver_pkg.sv
// rtl/ledr_pwm_driver_pkg.sv - register map, CTRL/STATUS bit layout for the red-LED PWM driver
package ledr_pwm_driver_pkg;

  localparam logic [1:0] ADDR_CTRL         = 2'd0;
  localparam logic [1:0] ADDR_BRIGHT       = 2'd1;
  localparam logic [1:0] ADDR_BLINK_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS       = 2'd3;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_SEEN_BIT  = 1;

  typedef struct packed {
    logic blink_en;
    logic enable;
  } ctrl_t;

  // Member order places frame_seen at bit 1 and blink_phase at bit 0.
  typedef struct packed {
    logic frame_seen;
    logic blink_phase;
  } status_t;

  function automatic logic [31:0] status_word(status_t s);
    return {30'b0, s};
  endfunction

endpackage

// File: rtl/ledr_pwm_driver_if.sv
// rtl/ledr_pwm_driver_if.sv - Avalon-MM style config slave bundle for the LED PWM driver
interface ledr_pwm_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ledr_pwm_timebase.sv
// rtl/ledr_pwm_timebase.sv - prescaler, PWM counter and frame strobe generation
module ledr_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_strobe
);

  // A 16-bit prescaler covers the whole legal PRESCALE range, including 1.
  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);

  logic [15:0]         psc_q, psc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    tick         = (psc_q == PSC_LAST);
    psc_d        = tick ? 16'd0 : psc_q + 16'd1;
    pwm_cnt_d    = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    frame_strobe = tick && (pwm_cnt_q == '1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q     <= 16'd0;
      pwm_cnt_q <= '0;
    end else begin
      psc_q     <= psc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/ledr_pwm_driver.sv
// rtl/ledr_pwm_driver.sv - frame-synchronous PWM/blink driver for the red LEDs
// Optional gamma duty curve: define LEDR_PWM_DRIVER_GAMMA_EN.
module ledr_pwm_driver
  import ledr_pwm_driver_pkg::*;
#(
  parameter int NUM_LEDS = 18,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_word,
  ledr_pwm_driver_if.slave    bus,
  output logic [NUM_LEDS-1:0] ledr
);

  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_strobe;
  logic                frame_evt;

  ledr_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .pwm_cnt      (pwm_cnt),
    .frame_strobe (frame_strobe)
  );

  assign frame_evt = tick && frame_strobe;

  ctrl_t               ctrl_q, ctrl_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [15:0]         blink_period_q, blink_period_d;
  logic [NUM_LEDS-1:0] shadow_q, shadow_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_seen_q, frame_seen_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;

  logic                wr_en;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_on;

  assign wr_en = bus.chipselect && !bus.write_n;

`ifdef LEDR_PWM_DRIVER_GAMMA_EN
  logic [2*PWM_BITS-1:0] bright_sq;

  always_comb begin
    bright_sq = {{PWM_BITS{1'b0}}, bright_q} * {{PWM_BITS{1'b0}}, bright_q};
    duty      = bright_sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  always_comb begin
    duty = bright_q;
  end
`endif

  // Full-scale BRIGHT must stay solidly on even though the curve maps it below all-ones.
  always_comb begin
    if (bright_q == '1) begin
      pwm_on = 1'b1;
    end else if (duty == '0) begin
      pwm_on = 1'b0;
    end else begin
      pwm_on = (pwm_cnt < duty);
    end
  end

  always_comb begin
    ctrl_d         = ctrl_q;
    bright_d       = bright_q;
    blink_period_d = blink_period_q;
    frame_seen_d   = frame_seen_q | frame_evt;
    if (wr_en) begin
      case (bus.address)
        ADDR_CTRL: begin
          ctrl_d.enable   = bus.writedata[CTRL_ENABLE_BIT];
          ctrl_d.blink_en = bus.writedata[CTRL_BLINK_EN_BIT];
        end
        ADDR_BRIGHT:       bright_d       = bus.writedata[PWM_BITS-1:0];
        ADDR_BLINK_PERIOD: blink_period_d = bus.writedata[15:0];
        default:           frame_seen_d   = 1'b0;
      endcase
    end
  end

  // A period shrunk below the running count lets the count run on through 65535.
  always_comb begin
    shadow_d      = frame_evt ? led_word : shadow_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!ctrl_q.blink_en || (blink_period_q == 16'd0)) begin
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b1;
    end else if (frame_evt) begin
      if (blink_cnt_q == blink_period_q - 16'd1) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
    ledr_d = (ctrl_q.enable && pwm_on && blink_phase_q) ? shadow_q : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q         <= '0;
      bright_q       <= '0;
      blink_period_q <= 16'd0;
      shadow_q       <= '0;
      blink_cnt_q    <= 16'd0;
      blink_phase_q  <= 1'b1;
      frame_seen_q   <= 1'b0;
      ledr_q         <= '0;
    end else begin
      ctrl_q         <= ctrl_d;
      bright_q       <= bright_d;
      blink_period_q <= blink_period_d;
      shadow_q       <= shadow_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      frame_seen_q   <= frame_seen_d;
      ledr_q         <= ledr_d;
    end
  end

  always_comb begin
    status_t status;
    status.frame_seen  = frame_seen_q;
    status.blink_phase = blink_phase_q;
    case (bus.address)
      ADDR_CTRL:         bus.readdata = {30'b0, ctrl_q};
      ADDR_BRIGHT:       bus.readdata = 32'(bright_q);
      ADDR_BLINK_PERIOD: bus.readdata = {16'b0, blink_period_q};
      default:           bus.readdata = status_word(status);
    endcase
  end

  assign ledr = ledr_q;

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// tb/tb_ledr_pwm_driver.sv - self-checking bench for ledr_pwm_driver (PRESCALE=2, PWM_BITS=8)
module tb_ledr_pwm_driver;

  localparam int NUM_LEDS = 18;
  localparam int FRAME    = 512;

  logic                clk      = 1'b0;
  logic                reset_n  = 1'b1;
  logic [NUM_LEDS-1:0] led_word = '0;
  logic [NUM_LEDS-1:0] ledr;

  ledr_pwm_driver_if bus ();

  ledr_pwm_driver #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_BITS (8),
    .PRESCALE (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .led_word (led_word),
    .bus      (bus.slave),
    .ledr     (ledr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: time since reset drives the PWM position; frame k spans clocks k*512 .. k*512+511.
  longint              n        = 0;
  bit                  m_en     = 0;
  bit                  m_ben    = 0;
  int                  m_bright = 0;
  int                  m_period = 0;
  int                  m_bcnt   = 0;
  bit                  m_phase  = 1;
  bit                  m_seen   = 0;
  logic [NUM_LEDS-1:0] m_shadow = '0;
  logic [NUM_LEDS-1:0] exp_ledr = '0;
  bit                  cmp_en   = 0;

  function automatic bit model_on(longint cyc, int br);
    int pc;
    int duty;
    pc = int'((cyc / 2) % 256);
`ifdef LEDR_PWM_DRIVER_GAMMA_EN
    duty = (br * br) / 256;
`else
    duty = br;
`endif
    return (br == 255) || (pc < duty);
  endfunction

  function automatic logic [31:0] model_rd(logic [1:0] a);
    case (a)
      2'd0:    return {30'b0, m_ben, m_en};
      2'd1:    return 32'(m_bright);
      2'd2:    return 32'(m_period);
      default: return {30'b0, m_seen, m_phase};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 0; m_en <= 0; m_ben <= 0; m_bright <= 0; m_period <= 0;
      m_bcnt <= 0; m_phase <= 1; m_seen <= 0; m_shadow <= '0; exp_ledr <= '0;
    end else begin
      exp_ledr <= (m_en && model_on(n, m_bright) && m_phase) ? m_shadow : '0;
      if ((n % FRAME) == FRAME - 1) begin
        m_shadow <= led_word;
        m_seen   <= 1;
      end
      if (!m_ben || m_period == 0) begin
        m_phase <= 1;
        m_bcnt  <= 0;
      end else if ((n % FRAME) == FRAME - 1) begin
        if (m_bcnt == m_period - 1) begin
          m_phase <= !m_phase;
          m_bcnt  <= 0;
        end else begin
          m_bcnt <= (m_bcnt + 1) % 65536;
        end
      end
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          2'd0:    {m_ben, m_en} <= bus.writedata[1:0];
          2'd1:    m_bright <= int'(bus.writedata[7:0]);
          2'd2:    m_period <= int'(bus.writedata[15:0]);
          default: m_seen <= 0;
        endcase
      end
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      check("ledr_cycle", 32'(ledr), 32'(exp_ledr));
      check("readdata_cycle", bus.readdata, model_rd(bus.address));
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic count_on(input logic [NUM_LEDS-1:0] pat, output int cnt);
    cnt = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (ledr == pat) cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < FRAME + 2; i++) begin
      if ((n % FRAME) == ph) break;
      cycles(1);
    end
    check("wait_phase_reached", 32'(n % FRAME), 32'(ph));
  endtask

  initial begin
    int  c;
    int  ph;
    int  bad;
    int  on_frames;
    bit  found;
    bit  s [8];

    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    #1 reset_n = 1'b0;
    cycles(3);
    check("reset_ledr", 32'(ledr), 32'h0);
    bus.address = 2'd3;
    #1;
    check("reset_status", bus.readdata, 32'h1);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cycles(2);

    // Duty: 0x40 of 256 ticks at 2 clk/tick.
    led_word = 18'h3FFFF;
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h40);
    cycles(FRAME + 8);
    count_on(18'h3FFFF, c);
    check("duty_40_on_clks", 32'(c), 32'd128);
    wr(2'd1, 32'hFF);
    cycles(4);
    count_on(18'h3FFFF, c);
    check("duty_ff_on_clks", 32'(c), 32'd512);
    wr(2'd1, 32'h0);
    cycles(4);
    count_on(18'h0, c);
    check("duty_00_off_clks", 32'(c), 32'd512);
    wr(2'd1, 32'h80);
    cycles(4);
    count_on(18'h3FFFF, c);
`ifdef LEDR_PWM_DRIVER_GAMMA_EN
    check("bright_80_on_ticks", 32'(c / 2), 32'd64);
`else
    check("bright_80_on_ticks", 32'(c / 2), 32'd128);
`endif

    // Shadow: a mid-frame change waits for the frame strobe.
    wr(2'd1, 32'hFF);
    led_word = 18'h00001;
    cycles(FRAME + 4);
    check("shadow_pre", 32'(ledr), 32'h1);
    wait_phase(200);
    led_word = 18'h20000;
    found = 0; ph = 999; bad = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      if (ledr == 18'h20000) begin
        ph = int'(n % FRAME);
        found = 1;
        break;
      end else if (ledr != 18'h00001) begin
        bad++;
      end
    end
    @(posedge clk);
    #1;
    check("shadow_switch_phase", 32'(ph), 32'd1);
    check("shadow_held", 32'(bad), 32'd0);

    // Blink: two frames on, two frames off.
    led_word = 18'h3FFFF;
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h3);
    bus.address = 2'd3;
    cycles(FRAME);
    wait_phase(256);
    on_frames = 0;
    for (int f = 0; f < 8; f++) begin
      s[f] = (ledr != '0);
      if (s[f]) on_frames++;
      check("blink_status_tracks", {31'b0, bus.readdata[0]}, {31'b0, s[f]});
      cycles(FRAME);
    end
    check("blink_on_frames", 32'(on_frames), 32'd4);
    for (int f = 0; f < 6; f++) begin
      check("blink_alternate", {31'b0, s[f] ^ s[f+2]}, 32'h1);
    end
    wr(2'd0, 32'h1);

    // STATUS bit1: sticky set by a strobe, write wins when coincident.
    wr(2'd3, 32'h0);
    wait_phase(10);
    bus.address = 2'd3;
    #1;
    check("status_sticky", {31'b0, bus.readdata[1]}, 32'h1);
    wait_phase(FRAME - 1);
    wr(2'd3, 32'h0);
    #1;
    check("status_coincident", {31'b0, bus.readdata[1]}, 32'h0);

    // Reset mid-run, then restart aligned to a fresh frame.
    wait_phase(300);
    reset_n = 1'b0;
    cmp_en  = 1'b0;
    #1;
    check("reset_midrun_ledr", 32'(ledr), 32'h0);
    bus.address = 2'd3;
    #1;
    check("reset_midrun_status", bus.readdata, 32'h1);
    bus.address = 2'd0;
    #1;
    check("reset_midrun_ctrl", bus.readdata, 32'h0);
    cycles(2);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cycles(20);
    led_word = 18'h15555;
    wr(2'd1, 32'h40);
    wr(2'd0, 32'h1);
    cycles(2 * FRAME);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
